// File: rtl/router_pkt_framer_if.sv
// ---------------------------------------------------------------------------
// router_pkt_framer_if
// Purpose : groups the payload-write, packet-control and router-side signals
//           of the packet framer into one bundle.
// Signals :
//   wr_en, wr_data        payload byte load into the framer buffer
//   dest, corrupt_par     packet options sampled when a start is accepted
//   start                 request transmission of the buffered packet
//   busy                  router back-pressure, stalls byte transfers
//   pkt_valid, data_out   packet byte stream towards the router
//   count, buf_full       buffer occupancy status
//   wr_drop               one-cycle pulse for a rejected write
//   tx_active, done       transmission status / end-of-packet pulse
// Modports: master = packet source / router side, slave = the framer.
// ---------------------------------------------------------------------------
interface router_pkt_framer_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [1:0] dest;
   logic       corrupt_par;
   logic       start;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic [4:0] count;
   logic       buf_full;
   logic       wr_drop;
   logic       tx_active;
   logic       done;

   modport master (
      output wr_en, wr_data, dest, corrupt_par, start, busy,
      input  pkt_valid, data_out, count, buf_full, wr_drop, tx_active, done
   );

   modport slave (
      input  wr_en, wr_data, dest, corrupt_par, start, busy,
      output pkt_valid, data_out, count, buf_full, wr_drop, tx_active, done
   );
endinterface

// File: rtl/router_pkt_framer.sv
// ---------------------------------------------------------------------------
// router_pkt_framer
// Purpose : buffers up to DEPTH payload bytes and, on start, sends a packet
//           header {len[5:0], dest[1:0]}, the payload in write order and an
//           XOR parity byte to a router that can stall with busy.
// Ports   :
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    router_pkt_framer_if.slave (write, control and router signals)
// ---------------------------------------------------------------------------
module router_pkt_framer #(
   parameter int DEPTH = 16
) (
   input logic                clk,
   input logic                rst_n,
   router_pkt_framer_if.slave bus
);

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [4:0] FULL = 5'(DEPTH);

   typedef enum logic [2:0] {IDLE, HDR, DATA, PAR, GAP} state_t;

   state_t     r_state;
   state_t     w_next;

   logic [7:0] r_buf [DEPTH];
   logic [4:0] r_count;
   logic [5:0] r_len;
   logic [1:0] r_dest;
   logic       r_corrupt;
   logic [7:0] r_parity;
   logic [4:0] r_idx;
   logic       r_wrDrop;

   logic       w_wrOk;
   logic       w_startOk;
   logic       w_xfer;
   logic       w_lastByte;
   logic       w_pktValid;
   logic [7:0] w_dataOut;
   logic [7:0] w_header;

   assign w_header   = {r_len, r_dest};
   assign w_wrOk     = bus.wr_en && (r_state == IDLE) && (r_count != FULL);
   assign w_startOk  = bus.start && (r_state == IDLE);
   assign w_xfer     = w_pktValid && !bus.busy;
   assign w_lastByte = ({1'b0, r_idx} == (r_len - 6'd1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and byte-stream outputs. Outputs are decoded from registered
   // state only, so with busy high nothing advances and the presented byte
   // simply holds until the router takes it.
   always_comb begin
      w_next     = r_state;
      w_pktValid = 1'b0;
      w_dataOut  = 8'h00;
      case (r_state)
         IDLE: begin
            if (bus.start) w_next = HDR;
         end
         HDR: begin
            w_pktValid = 1'b1;
            w_dataOut  = w_header;
            if (!bus.busy) w_next = (r_len == 6'd0) ? PAR : DATA;
         end
         DATA: begin
            w_pktValid = 1'b1;
            w_dataOut  = r_buf[r_idx[AW-1:0]];
            if (!bus.busy && w_lastByte) w_next = PAR;
         end
         PAR: begin
            w_pktValid = 1'b1;
            w_dataOut  = r_parity ^ {8{r_corrupt}};
            if (!bus.busy) w_next = GAP;
         end
         GAP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Packet bookkeeping. A write in the same cycle as start is stored first,
   // so it is counted in len. Parity restarts at each start and folds in each
   // byte as it transfers; the buffer is emptied when the parity byte goes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= 5'd0;
         r_len     <= 6'd0;
         r_dest    <= 2'd0;
         r_corrupt <= 1'b0;
         r_parity  <= 8'h00;
         r_idx     <= 5'd0;
         r_wrDrop  <= 1'b0;
      end else begin
         r_wrDrop <= bus.wr_en && !w_wrOk;
         if (w_wrOk) begin
            r_count <= r_count + 5'd1;
         end
         if (w_startOk) begin
            r_len     <= w_wrOk ? ({1'b0, r_count} + 6'd1) : {1'b0, r_count};
            r_dest    <= bus.dest;
            r_corrupt <= bus.corrupt_par;
            r_parity  <= 8'h00;
            r_idx     <= 5'd0;
         end
         if (w_xfer) begin
            case (r_state)
               HDR:  r_parity <= r_parity ^ w_header;
               DATA: begin
                  r_parity <= r_parity ^ w_dataOut;
                  r_idx    <= r_idx + 5'd1;
               end
               PAR:  r_count <= 5'd0;
               default: ;
            endcase
         end
      end
   end

   // Payload storage has no reset; count alone defines which bytes are valid.
   always_ff @(posedge clk) begin
      if (w_wrOk) begin
         r_buf[r_count[AW-1:0]] <= bus.wr_data;
      end
   end

   assign bus.pkt_valid = w_pktValid;
   assign bus.data_out  = w_dataOut;
   assign bus.count     = r_count;
   assign bus.buf_full  = (r_count == FULL);
   assign bus.wr_drop   = r_wrDrop;
   assign bus.tx_active = (r_state != IDLE);
   assign bus.done      = (r_state == GAP);

endmodule

// File: tb/tb_router_pkt_framer.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_framer
// Purpose : directed stimulus for router_pkt_framer with a byte scoreboard.
//           Stimulus pushes the hand-computed packet bytes into expQ; the
//           monitor pops and compares every byte the router accepts.
// ---------------------------------------------------------------------------
module tb_router_pkt_framer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   router_pkt_framer_if bus ();

   router_pkt_framer #(.DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         errors   = 0;
   int         doneSeen = 0;
   int         expDones = 0;
   int         curRun   = 0;
   int         lastRun  = 0;
   logic [7:0] expQ [$];

   // Shared comparison: counts every check and reports any difference.
   task automatic checkOutput(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Holds the given inputs across one rising edge, returning just after it.
   task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic st,
                                input logic [1:0] ds, input logic cp, input logic bz);
      bus.wr_en       = we;
      bus.wr_data     = wd;
      bus.start       = st;
      bus.dest        = ds;
      bus.corrupt_par = cp;
      bus.busy        = bz;
      @(posedge clk);
      #1;
   endtask

   // Lets the packet drain, then checks that every expected byte went out,
   // that exactly one done pulse appeared and the valid window length.
   task automatic finishPacket(input string name, input int expRun);
      int n = 0;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      bus.busy  = 1'b0;
      while (bus.tx_active && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({name, "_timeout"}, int'(bus.tx_active), 0);
      checkOutput({name, "_leftover"}, expQ.size(), 0);
      expQ.delete();
      expDones++;
      checkOutput({name, "_done"}, doneSeen, expDones);
      checkOutput({name, "_validrun"}, lastRun, expRun);
      checkOutput({name, "_count"}, int'(bus.count), 0);
   endtask

   // Monitor: a byte is taken by the router on the next rising edge whenever
   // pkt_valid is high and busy is low at the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         curRun = 0;
      end else begin
         if (bus.pkt_valid && !bus.busy) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_byte got 0x%0h expected none", bus.data_out);
            end else begin
               checkOutput("byte", int'(bus.data_out), int'(expQ.pop_front()));
            end
         end
         if (bus.pkt_valid) begin
            curRun++;
         end else begin
            checkOutput("idle_data", int'(bus.data_out), 0);
            if (curRun > 0) lastRun = curRun;
            curRun = 0;
         end
         if (bus.done) doneSeen++;
      end
   end

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.start = 1'b0;
      bus.dest = 2'd0; bus.corrupt_par = 1'b0; bus.busy = 1'b0;

      // Reset state.
      #1;
      checkOutput("rst_valid", int'(bus.pkt_valid), 0);
      checkOutput("rst_data", int'(bus.data_out), 0);
      checkOutput("rst_count", int'(bus.count), 0);
      checkOutput("rst_full", int'(bus.buf_full), 0);
      checkOutput("rst_drop", int'(bus.wr_drop), 0);
      checkOutput("rst_active", int'(bus.tx_active), 0);
      checkOutput("rst_done", int'(bus.done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 8'h00, 0, 0, 0, 0);

      // Three-byte packet to channel 0.
      $display("[TB] packet AA 55 CC");
      applyStimulus(1, 8'hAA, 0, 0, 0, 0);
      applyStimulus(1, 8'h55, 0, 0, 0, 0);
      applyStimulus(1, 8'hCC, 0, 0, 0, 0);
      checkOutput("p1_count", int'(bus.count), 3);
      expQ.push_back(8'h0C); expQ.push_back(8'hAA); expQ.push_back(8'h55);
      expQ.push_back(8'hCC); expQ.push_back(8'h3F);
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
      checkOutput("p1_hdr_valid", int'(bus.pkt_valid), 1);
      checkOutput("p1_hdr_data", int'(bus.data_out), 8'h0C);
      finishPacket("p1", 5);

      // Zero-length packet to channel 2.
      $display("[TB] zero-length packet");
      expQ.push_back(8'h02); expQ.push_back(8'h02);
      applyStimulus(0, 8'h00, 1, 2, 0, 0);
      finishPacket("p2", 2);

      // Router stalls while 0x22 is presented.
      $display("[TB] busy stall");
      applyStimulus(1, 8'h11, 0, 0, 0, 0);
      applyStimulus(1, 8'h22, 0, 0, 0, 0);
      expQ.push_back(8'h09); expQ.push_back(8'h11); expQ.push_back(8'h22);
      expQ.push_back(8'h3A);
      applyStimulus(0, 8'h00, 1, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("p3_stall_data", int'(bus.data_out), 8'h22);
         applyStimulus(0, 8'h00, 0, 0, 0, 1);
      end
      checkOutput("p3_held_data", int'(bus.data_out), 8'h22);
      checkOutput("p3_held_valid", int'(bus.pkt_valid), 1);
      finishPacket("p3", 7);

      // Fill to capacity; the seventeenth write is rejected.
      $display("[TB] full buffer");
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1, {k[3:0], k[3:0]}, 0, 0, 0, 0);
      end
      checkOutput("p4_drop_before", int'(bus.wr_drop), 0);
      applyStimulus(1, 8'h99, 0, 0, 0, 0);
      checkOutput("p4_count", int'(bus.count), 16);
      checkOutput("p4_full", int'(bus.buf_full), 1);
      checkOutput("p4_drop", int'(bus.wr_drop), 1);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      checkOutput("p4_drop_pulse", int'(bus.wr_drop), 0);
      expQ.push_back(8'h40);
      for (int k = 0; k < 16; k++) begin
         logic [3:0] nib;
         nib = 4'(k);
         expQ.push_back({nib, nib});
      end
      expQ.push_back(8'h40);
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
      finishPacket("p4", 18);

      // Corrupted parity; a write during transmission is dropped and the
      // option inputs change after start without effect.
      $display("[TB] corrupt parity");
      applyStimulus(1, 8'hFF, 0, 0, 0, 0);
      expQ.push_back(8'h06); expQ.push_back(8'hFF); expQ.push_back(8'h06);
      applyStimulus(0, 8'h00, 1, 2, 1, 0);
      applyStimulus(1, 8'h77, 0, 1, 0, 0);
      checkOutput("p5_drop", int'(bus.wr_drop), 1);
      checkOutput("p5_count", int'(bus.count), 1);
      finishPacket("p5", 3);

      // Write and start in the same cycle: the byte joins the packet.
      $display("[TB] write with start");
      expQ.push_back(8'h07); expQ.push_back(8'h5A); expQ.push_back(8'h5D);
      applyStimulus(1, 8'h5A, 1, 3, 0, 0);
      checkOutput("p6_drop", int'(bus.wr_drop), 0);
      finishPacket("p6", 3);

      // Reset during the payload aborts the packet without done.
      $display("[TB] reset mid-packet");
      applyStimulus(1, 8'h01, 0, 0, 0, 0);
      applyStimulus(1, 8'h02, 0, 0, 0, 0);
      applyStimulus(1, 8'h03, 0, 0, 0, 0);
      expQ.push_back(8'h0D);
      applyStimulus(0, 8'h00, 1, 1, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      checkOutput("p7_in_data", int'(bus.data_out), 8'h01);
      rst_n = 1'b0;
      #1;
      checkOutput("p7_rst_valid", int'(bus.pkt_valid), 0);
      checkOutput("p7_rst_count", int'(bus.count), 0);
      checkOutput("p7_rst_active", int'(bus.tx_active), 0);
      checkOutput("p7_leftover", expQ.size(), 0);
      expQ.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      checkOutput("p7_no_done", doneSeen, expDones);
      applyStimulus(1, 8'h44, 0, 0, 0, 0);
      expQ.push_back(8'h07); expQ.push_back(8'h44); expQ.push_back(8'h43);
      applyStimulus(0, 8'h00, 1, 3, 0, 0);
      finishPacket("p7", 3);

      applyStimulus(0, 8'h00, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
